// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller: register index width,
// default tag/data widths, the "no tag" status value and the sequencer states.
package operand_fetch_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_TAG_W  = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NOTAG  = 1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_RES1 = 3'd2,
    ST_RES2 = 3'd3,
    ST_SEND = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/operand_fetch_ctrl_operand_slot.sv
// One held {V,Q} operand pair with CDB/commit snoop, ROB-query capture and
// a combinational snooped view so a same-cycle broadcast is visible at once.
module operand_slot
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NOTAG  = DEF_NOTAG
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_v,
  input  logic [TAG_W-1:0]  load_q,
  input  logic              snoop_en,
  input  logic              rob_hit,
  input  logic [DATA_W-1:0] rob_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              cm_valid,
  input  logic [TAG_W-1:0]  cm_tag,
  input  logic [DATA_W-1:0] cm_value,
  output logic [TAG_W-1:0]  q_held,
  output logic [DATA_W-1:0] v_snp,
  output logic [TAG_W-1:0]  q_snp
);

  localparam logic [TAG_W-1:0] NT = TAG_W'(NOTAG);

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } pair_t;

  pair_t held, held_res, load_in, load_res;

  // CDB wins over commit when both carry the pending tag
  function automatic pair_t snoop(input pair_t p);
    pair_t r;
    r = p;
    if (p.q != NT) begin
      if (cdb_valid && cdb_tag == p.q) begin
        r.v = cdb_value;
        r.q = NT;
      end else if (cm_valid && cm_tag == p.q) begin
        r.v = cm_value;
        r.q = NT;
      end
    end
    return r;
  endfunction

  always_comb begin
    load_in  = {load_v, load_q};
    load_res = snoop(load_in);
    held_res = snoop(held);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      held.v <= '0;
      held.q <= NT;
    end else if (en) begin
      if (load) begin
        held <= load_res;
      end else if (snoop_en) begin
        if (rob_hit && held_res.q != NT) begin
          held.v <= rob_value;
          held.q <= NT;
        end else begin
          held <= held_res;
        end
      end
    end
  end

  assign q_held = held.q;
  assign v_snp  = held_res.v;
  assign q_snp  = held_res.q;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Issue-side operand sequencer: reads rs1/rs2 from the renamed regfile,
// resolves pending tags via ROB query and bus snoop, then hands off and renames rd.
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int NOTAG  = DEF_NOTAG,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic                  dec_write_rd,
  input  logic [TAG_W-1:0]      dec_rob_tag,
  output logic                  rf_en_1,
  output logic                  rf_en_2,
  output logic [REG_ADDR_W-1:0] rf_addr_1,
  output logic [REG_ADDR_W-1:0] rf_addr_2,
  input  logic [TAG_W-1:0]      rf_status_1,
  input  logic [TAG_W-1:0]      rf_status_2,
  input  logic [DATA_W-1:0]     rf_data_1,
  input  logic [DATA_W-1:0]     rf_data_2,
  output logic                  rob_qry_valid,
  output logic [TAG_W-1:0]      rob_qry_tag,
  input  logic                  rob_qry_ready,
  input  logic [DATA_W-1:0]     rob_qry_value,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_value,
  input  logic                  cm_valid,
  input  logic [TAG_W-1:0]      cm_tag,
  input  logic [DATA_W-1:0]     cm_value,
  output logic                  rf_rename_en,
  output logic [REG_ADDR_W-1:0] rf_rename_addr,
  output logic [TAG_W-1:0]      rf_rename_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_vj,
  output logic [DATA_W-1:0]     out_vk,
  output logic [TAG_W-1:0]      out_qj,
  output logic [TAG_W-1:0]      out_qk,
  output logic [TAG_W-1:0]      out_rob_tag
);

  localparam logic [TAG_W-1:0] NT = TAG_W'(NOTAG);

  fetch_state_e          state, state_nxt;
  logic [REG_ADDR_W-1:0] rs1_r, rs2_r, rd_r;
  logic                  use1_r, use2_r, wr_r;
  logic [TAG_W-1:0]      tag_r;
  logic [TAG_W-1:0]      qj_held, qk_held;
  logic [DATA_W-1:0]     load_vj, load_vk;
  logic [TAG_W-1:0]      load_qj, load_qk;
  logic                  load_en, snoop_en, rob_hit_j, rob_hit_k;

  always_comb begin
    state_nxt     = state;
    dec_ready     = 1'b0;
    rf_en_1       = 1'b0;
    rf_en_2       = 1'b0;
    rob_qry_valid = 1'b0;
    rob_qry_tag   = qj_held;
    out_valid     = 1'b0;
    rf_rename_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        dec_ready = rdy_in && !clear_in;
        if (dec_valid && dec_ready) state_nxt = ST_READ;
      end
      ST_READ: begin
        rf_en_1   = 1'b1;
        rf_en_2   = 1'b1;
        state_nxt = ST_RES1;
      end
      ST_RES1: begin
        rob_qry_valid = rdy_in && (qj_held != NT);
        rob_qry_tag   = qj_held;
        state_nxt     = ST_RES2;
      end
      ST_RES2: begin
        rob_qry_valid = rdy_in && (qk_held != NT);
        rob_qry_tag   = qk_held;
        state_nxt     = ST_SEND;
      end
      ST_SEND: begin
        out_valid = rdy_in && !clear_in;
        if (out_valid && out_ready) begin
          rf_rename_en = wr_r && (rd_r != '0);
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) state <= ST_IDLE;
    else if (rdy_in)        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (dec_valid && dec_ready) begin
      rs1_r  <= dec_rs1;
      rs2_r  <= dec_rs2;
      rd_r   <= dec_rd;
      use1_r <= dec_use_rs1;
      use2_r <= dec_use_rs2;
      wr_r   <= dec_write_rd;
      tag_r  <= dec_rob_tag;
    end
  end

  // x0 or an unused source never depends on the regfile status
  always_comb begin
    load_vj = '0;
    load_qj = NT;
    load_vk = '0;
    load_qk = NT;
    if (use1_r && rs1_r != '0) begin
      load_vj = rf_data_1;
      load_qj = rf_status_1;
    end
    if (use2_r && rs2_r != '0) begin
      load_vk = rf_data_2;
      load_qk = rf_status_2;
    end
  end

  assign load_en   = (state == ST_READ);
  assign snoop_en  = (state == ST_RES1) || (state == ST_RES2) || (state == ST_SEND);
  assign rob_hit_j = (state == ST_RES1) && rob_qry_valid && rob_qry_ready;
  assign rob_hit_k = (state == ST_RES2) && rob_qry_valid && rob_qry_ready;

  operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NOTAG(NOTAG)) u_slot_j (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clr       (clear_in),
    .load      (load_en),
    .load_v    (load_vj),
    .load_q    (load_qj),
    .snoop_en  (snoop_en),
    .rob_hit   (rob_hit_j),
    .rob_value (rob_qry_value),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cm_valid  (cm_valid),
    .cm_tag    (cm_tag),
    .cm_value  (cm_value),
    .q_held    (qj_held),
    .v_snp     (out_vj),
    .q_snp     (out_qj)
  );

  operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NOTAG(NOTAG)) u_slot_k (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clr       (clear_in),
    .load      (load_en),
    .load_v    (load_vk),
    .load_q    (load_qk),
    .snoop_en  (snoop_en),
    .rob_hit   (rob_hit_k),
    .rob_value (rob_qry_value),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cm_valid  (cm_valid),
    .cm_tag    (cm_tag),
    .cm_value  (cm_value),
    .q_held    (qk_held),
    .v_snp     (out_vk),
    .q_snp     (out_qk)
  );

  assign rf_addr_1      = rs1_r;
  assign rf_addr_2      = rs2_r;
  assign rf_rename_addr = rd_r;
  assign rf_rename_tag  = tag_r;
  assign out_rob_tag    = tag_r;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked each cycle against a transaction-level model.
module tb_operand_fetch_ctrl;

  localparam int TAG_W  = 32;
  localparam int DATA_W = 32;
  localparam int NOTAG  = 1000;
  localparam logic [31:0] NT = 32'd1000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_write_rd;
  logic [31:0] dec_rob_tag;
  logic        rf_en_1, rf_en_2;
  logic [4:0]  rf_addr_1, rf_addr_2;
  logic [31:0] rf_status_1, rf_status_2, rf_data_1, rf_data_2;
  logic        rob_qry_valid, rob_qry_ready;
  logic [31:0] rob_qry_tag, rob_qry_value;
  logic        cdb_valid, cm_valid;
  logic [31:0] cdb_tag, cdb_value, cm_tag, cm_value;
  logic        rf_rename_en;
  logic [4:0]  rf_rename_addr;
  logic [31:0] rf_rename_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_vj, out_vk, out_qj, out_qk, out_rob_tag;

  always #5 clk_in = ~clk_in;

  operand_fetch_ctrl #(.TAG_W(TAG_W), .NOTAG(NOTAG), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_write_rd(dec_write_rd),
    .dec_rob_tag(dec_rob_tag),
    .rf_en_1(rf_en_1), .rf_en_2(rf_en_2), .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_status_1(rf_status_1), .rf_status_2(rf_status_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .rob_qry_valid(rob_qry_valid), .rob_qry_tag(rob_qry_tag),
    .rob_qry_ready(rob_qry_ready), .rob_qry_value(rob_qry_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_value(cm_value),
    .rf_rename_en(rf_rename_en), .rf_rename_addr(rf_rename_addr), .rf_rename_tag(rf_rename_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vj(out_vj), .out_vk(out_vk), .out_qj(out_qj), .out_qk(out_qk),
    .out_rob_tag(out_rob_tag)
  );

  // Environment: regfile contents and ROB behaviour
  logic [31:0] rf_st [32];
  logic [31:0] rf_dt [32];
  logic        rob_rdy_r;
  logic [31:0] rob_val_r;

  function automatic logic [31:0] rob_resp(input logic [31:0] t,
      input logic cv, input logic [31:0] ct, input logic [31:0] cval,
      input logic mv, input logic [31:0] mt, input logic [31:0] mval,
      input logic [31:0] rv);
    if (cv && ct == t) return cval;
    if (mv && mt == t) return mval;
    return rv;
  endfunction

  always_comb begin
    rf_status_1   = rf_st[rf_addr_1];
    rf_status_2   = rf_st[rf_addr_2];
    rf_data_1     = rf_dt[rf_addr_1];
    rf_data_2     = rf_dt[rf_addr_2];
    rob_qry_ready = rob_qry_valid && rob_rdy_r;
    rob_qry_value = rob_resp(rob_qry_tag, cdb_valid, cdb_tag, cdb_value,
                             cm_valid, cm_tag, cm_value, rob_val_r);
  end

  int total = 0;
  int bad   = 0;
  int accepts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void snp(input logic [31:0] v, input logic [31:0] q,
                              output logic [31:0] nv, output logic [31:0] nq);
    nv = v;
    nq = q;
    if (q != NT) begin
      if (cdb_valid && cdb_tag == q) begin
        nv = cdb_value; nq = NT;
      end else if (cm_valid && cm_tag == q) begin
        nv = cm_value; nq = NT;
      end
    end
  endfunction

  // Transaction model: one instruction in flight, m_k counts enabled cycles since accept
  logic        m_busy;
  int          m_k;
  logic [4:0]  m_rs [2];
  logic        m_use [2];
  logic [4:0]  m_rd;
  logic        m_wr;
  logic [31:0] m_tag;
  logic [31:0] m_v [2];
  logic [31:0] m_q [2];

  initial begin : compare
    logic [31:0] sv [2];
    logic [31:0] sq [2];
    logic        qv, ov, acc, ren;
    logic [31:0] st, dt;
    int          r;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        m_busy = 1'b0; m_k = 0;
        m_v[0] = '0; m_v[1] = '0; m_q[0] = NT; m_q[1] = NT;
      end else begin
        for (int i = 0; i < 2; i++) snp(m_v[i], m_q[i], sv[i], sq[i]);
        chk("dec_ready", dec_ready, !m_busy && rdy_in && !clear_in);
        chk("rf_en_1", rf_en_1, m_busy && m_k == 1);
        chk("rf_en_2", rf_en_2, m_busy && m_k == 1);
        if (m_busy && m_k == 1) begin
          chk("rf_addr_1", rf_addr_1, m_rs[0]);
          chk("rf_addr_2", rf_addr_2, m_rs[1]);
        end
        qv = rdy_in && m_busy && ((m_k == 2 && m_q[0] != NT) || (m_k == 3 && m_q[1] != NT));
        chk("rob_qry_valid", rob_qry_valid, qv);
        if (qv) chk("rob_qry_tag", rob_qry_tag, (m_k == 2) ? m_q[0] : m_q[1]);
        ov = rdy_in && !clear_in && m_busy && m_k >= 4;
        chk("out_valid", out_valid, ov);
        if (ov) begin
          chk("out_qj", out_qj, sq[0]);
          chk("out_qk", out_qk, sq[1]);
          if (sq[0] == NT) chk("out_vj", out_vj, sv[0]);
          if (sq[1] == NT) chk("out_vk", out_vk, sv[1]);
          chk("out_rob_tag", out_rob_tag, m_tag);
        end
        acc = ov && out_ready;
        ren = acc && m_wr && m_rd != 0;
        chk("rename_en", rf_rename_en, ren);
        if (ren) begin
          chk("rename_addr", rf_rename_addr, m_rd);
          chk("rename_tag", rf_rename_tag, m_tag);
        end
        if (acc) accepts++;

        if (clear_in) begin
          m_busy = 1'b0;
          m_v[0] = '0; m_v[1] = '0; m_q[0] = NT; m_q[1] = NT;
        end else if (rdy_in) begin
          if (!m_busy) begin
            if (dec_valid) begin
              m_rs[0] = dec_rs1; m_rs[1] = dec_rs2;
              m_use[0] = dec_use_rs1; m_use[1] = dec_use_rs2;
              m_rd = dec_rd; m_wr = dec_write_rd; m_tag = dec_rob_tag;
              m_busy = 1'b1; m_k = 1;
            end
          end else if (m_k == 1) begin
            for (int i = 0; i < 2; i++) begin
              if (!m_use[i] || m_rs[i] == 0) begin
                m_v[i] = '0; m_q[i] = NT;
              end else begin
                st = rf_st[m_rs[i]];
                dt = rf_dt[m_rs[i]];
                snp(dt, st, m_v[i], m_q[i]);
              end
            end
            m_k = 2;
          end else if (m_k == 2 || m_k == 3) begin
            r = m_k - 2;
            if (m_q[r] != NT && sq[r] != NT && rob_rdy_r) begin
              sv[r] = rob_resp(m_q[r], cdb_valid, cdb_tag, cdb_value,
                               cm_valid, cm_tag, cm_value, rob_val_r);
              sq[r] = NT;
            end
            for (int i = 0; i < 2; i++) begin
              m_v[i] = sv[i]; m_q[i] = sq[i];
            end
            m_k = m_k + 1;
          end else begin
            for (int i = 0; i < 2; i++) begin
              m_v[i] = sv[i]; m_q[i] = sq[i];
            end
            if (out_ready) m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr, input logic [31:0] tag);
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_write_rd = wr; dec_rob_tag = tag;
    dec_valid = 1'b1;
    @(negedge clk_in);
    chk("issue_ready", dec_ready, 1'b1);
    tick();
    dec_valid = 1'b0;
  endtask

  // Returns at the negedge of the first out_valid cycle; n counts cycles since accept
  task automatic wait_send(output int n);
    n = 1;
    while (1) begin
      @(negedge clk_in);
      if (out_valid) return;
      if (n >= 20) begin
        chk("send_timeout", out_valid, 1'b1);
        return;
      end
      tick();
      n++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_write_rd = 1'b0; dec_rob_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    cm_valid = 1'b0; cm_tag = '0; cm_value = '0;
    out_ready = 1'b0; rob_rdy_r = 1'b0; rob_val_r = '0;
    for (int i = 0; i < 32; i++) begin
      rf_st[i] = NT; rf_dt[i] = '0;
    end
    tick();
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_dec_ready", dec_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rename_en", rf_rename_en, 1'b0);
    chk("rst_rob_qry", rob_qry_valid, 1'b0);
    chk("rst_rf_en_1", rf_en_1, 1'b0);
    chk("rst_rf_en_2", rf_en_2, 1'b0);
    tick();

    // Both sources architectural, rd aliases rs1
    rf_dt[5] = 32'd7; rf_dt[6] = 32'd9; out_ready = 1'b1;
    issue(5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 32'd3);
    wait_send(n);
    chk("t1_latency", n, 4);
    chk("t1_vj", out_vj, 32'd7);
    chk("t1_vk", out_vk, 32'd9);
    chk("t1_qj", out_qj, NT);
    chk("t1_qk", out_qk, NT);
    chk("t1_rename_en", rf_rename_en, 1'b1);
    chk("t1_rename_addr", rf_rename_addr, 5'd5);
    chk("t1_rename_tag", rf_rename_tag, 32'd3);
    tick();
    @(negedge clk_in);
    chk("t1_rename_after", rf_rename_en, 1'b0);
    chk("t1_valid_after", out_valid, 1'b0);
    chk("t1_idle", dec_ready, 1'b1);
    tick();

    // rs1 tagged, ROB already has the result
    rf_st[5] = 32'd12; rob_rdy_r = 1'b1; rob_val_r = 32'h55;
    issue(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 32'd8);
    wait_send(n);
    chk("t2_vj", out_vj, 32'h55);
    chk("t2_qj", out_qj, NT);
    chk("t2_vk", out_vk, 32'd0);
    tick();
    // same, ROB not ready
    rob_rdy_r = 1'b0;
    issue(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 32'd9);
    wait_send(n);
    chk("t2b_qj", out_qj, 32'd12);
    tick();

    // rs2 pending, CDB broadcast while SEND is stalled
    rf_st[5] = NT; rf_st[6] = 32'd4; out_ready = 1'b0;
    issue(5'd5, 5'd6, 5'd1, 1'b1, 1'b1, 1'b1, 32'd10);
    wait_send(n);
    chk("t3_qk_pending", out_qk, 32'd4);
    tick();
    cdb_valid = 1'b1; cdb_tag = 32'd4; cdb_value = 32'hAB;
    @(negedge clk_in);
    chk("t3_vk_comb", out_vk, 32'hAB);
    chk("t3_qk_comb", out_qk, NT);
    tick();
    cdb_valid = 1'b0;
    @(negedge clk_in);
    chk("t3_vk_held", out_vk, 32'hAB);
    chk("t3_qk_held", out_qk, NT);
    tick();
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t3_accept", out_valid, 1'b1);
    tick();

    // clear in RES1
    issue(5'd5, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 32'd11);
    tick();
    clear_in = 1'b1;
    @(negedge clk_in);
    chk("t4a_valid", out_valid, 1'b0);
    tick();
    clear_in = 1'b0;
    @(negedge clk_in);
    chk("t4a_idle", dec_ready, 1'b1);
    tick();
    // clear in SEND with out_ready high
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'd12);
    wait_send(n);
    tick();
    clear_in = 1'b1; out_ready = 1'b1;
    @(negedge clk_in);
    chk("t4b_no_rename", rf_rename_en, 1'b0);
    chk("t4b_valid", out_valid, 1'b0);
    tick();
    clear_in = 1'b0;
    @(negedge clk_in);
    chk("t4b_idle", dec_ready, 1'b1);
    chk("t4b_valid_after", out_valid, 1'b0);
    chk("t4b_rename_after", rf_rename_en, 1'b0);
    tick();

    // rdy_in low for three cycles in RES2
    rf_dt[5] = 32'h11; rf_st[6] = 32'd7; rob_rdy_r = 1'b1; rob_val_r = 32'h22;
    issue(5'd5, 5'd6, 5'd4, 1'b1, 1'b1, 1'b1, 32'd13);
    tick();
    tick();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      chk("t5_no_qry", rob_qry_valid, 1'b0);
      chk("t5_no_valid", out_valid, 1'b0);
      chk("t5_no_rename", rf_rename_en, 1'b0);
      tick();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("t5_qry", rob_qry_valid, 1'b1);
    chk("t5_qry_tag", rob_qry_tag, 32'd7);
    tick();
    wait_send(n);
    chk("t5_vj", out_vj, 32'h11);
    chk("t5_vk", out_vk, 32'h22);
    chk("t5_qk", out_qk, NT);
    tick();

    // x0 source and x0 destination
    rf_st[0] = 32'd9; rf_dt[0] = 32'h99; rob_val_r = 32'h66;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'd14);
    tick();
    @(negedge clk_in);
    chk("t6_no_qry", rob_qry_valid, 1'b0);
    tick();
    wait_send(n);
    chk("t6_vj", out_vj, 32'd0);
    chk("t6_qj", out_qj, NT);
    chk("t6_no_rename", rf_rename_en, 1'b0);
    tick();
    rf_st[0] = NT;

    // Randomized traffic against the model
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in    = ($urandom % 8) != 0;
      clear_in  = ($urandom % 50) == 0;
      out_ready = ($urandom % 3) != 0;
      dec_valid = $urandom % 2;
      dec_rs1 = 5'($urandom % 8); dec_rs2 = 5'($urandom % 8); dec_rd = 5'($urandom % 8);
      dec_use_rs1 = $urandom % 2; dec_use_rs2 = $urandom % 2; dec_write_rd = $urandom % 2;
      dec_rob_tag = 32'(16 + $urandom % 16);
      cdb_valid = ($urandom % 3) == 0;
      cdb_tag   = (($urandom % 16) == 0) ? NT : 32'(1 + $urandom % 15);
      cdb_value = $urandom;
      cm_valid  = ($urandom % 3) == 0;
      cm_tag    = (($urandom % 16) == 0) ? NT : 32'(1 + $urandom % 15);
      cm_value  = $urandom;
      rob_rdy_r = $urandom % 2;
      rob_val_r = $urandom;
      for (int r = 0; r < 8; r++) begin
        if (($urandom % 4) == 0) begin
          rf_st[r] = ($urandom % 2) ? NT : 32'(1 + $urandom % 15);
          rf_dt[r] = $urandom;
        end
      end
      tick();
    end
    @(negedge clk_in);
    chk("rand_accepts", accepts > 20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
